pdl_sweep_ctrl: RTL and testbench
=================================

Name: pdl_sweep_ctrl

Overview:
- Parametrised controller for programmable delay lines (PDLs).
- Drives the shared N_LUT-bit delay-control word and launches test edges into N_CH PDL/arbiter channels.
- Synchronises each channel's arbiter output and counts '1' responses over SAMPLES trials per code.
- Static mode measures one configured code. Sweep mode steps a thermometer code 0..N_LUT and reports one result per code over a valid/ready handshake.

Parameters:
N_LUT, 125, LUTs per delay line / control word width
N_CH, 1, number of PDL/arbiter channels
SAMPLES, 16, trials per code (>=1)
SETTLE, 4, cycles of settle after control change and after each launch release (>=1)
HOLD, 4, cycles launch is held high per trial (>=3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run when idle
abort  in  1  synchronous abort, any state
mode  in  1  0 = static, 1 = sweep; captured at start
cfg_c  in  N_LUT  static control word; captured at start
ctrl_c  out  N_LUT  control word to all PDLs
launch  out  1  test edge into all PDLs
arb_in  in  N_CH  raw arbiter outputs (asynchronous)
busy  out  1  run in progress
res_valid  out  1  result available
res_ready  in  1  result consumed
res_code  out  CW  thermometer code of result, CW = $clog2(N_LUT+1); 0 in static mode
res_count  out  N_CH*CNT_W  per-channel ones count, CNT_W = $clog2(SAMPLES+1), channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset: all outputs 0; state IDLE; counters, code and trial index cleared. Reset asserted mid-run: launch drops immediately; no result is emitted.
- arb_in passes through a 2-flop synchroniser per channel (arb_sync).
- IDLE: start=1 captures mode and cfg_c, code=0, trial=0, counts=0, then SETUP. busy=1 from the next cycle. start is ignored in every other state.
- SETUP: ctrl_c = cfg_c (static) or thermometer(code), i.e. the low `code` bits set. Lasts SETTLE cycles, then LAUNCH.
- LAUNCH: launch=1 for HOLD cycles. On the last cycle, count[i] += arb_sync[i] for all i. Then RELAX.
- RELAX: launch=0 for SETTLE cycles.
  - trial < SAMPLES-1: trial++, go to LAUNCH; ctrl_c unchanged.
  - otherwise: go to REPORT.
- REPORT: res_valid=1. res_code and res_count are stable while res_valid=1 and res_ready=0. No launch while waiting. On the cycle with res_valid && res_ready:
  - static, or code == N_LUT: go to IDLE; busy=0 next cycle.
  - otherwise: code++, trial=0, counts=0, go to SETUP.
- Timing: first res_valid rises SETTLE + SAMPLES*(HOLD+SETTLE) cycles after entering SETUP.
- Sweep emits exactly N_LUT+1 results, codes 0..N_LUT in order.
- abort=1: next edge enters IDLE. launch=0, res_valid=0, busy=0, counts cleared. abort has priority over start and the handshake.
- ctrl_c holds its last applied value in IDLE; it is cleared only by reset.
- Counts cannot overflow, since CNT_W covers SAMPLES.
- Any other state encoding: recover to IDLE.

Test Plan:
- Parameters for all scenarios: N_LUT=8, N_CH=2, SAMPLES=4, SETTLE=2, HOLD=3.
- Static: start with mode=0, cfg_c=8'hA5, arb_in=2'b01 held -> ctrl_c=8'hA5; res_valid rises 22 cycles after SETUP entry; res_code=0, count ch0=4, ch1=0; busy falls the cycle after the handshake.
- Sweep: mode=1, res_ready=1, arb_in[0] driven = ctrl_c[4], arb_in[1]=0 -> 9 results with codes 0..8 and ctrl_c 00,01,03,07,0F,1F,3F,7F,FF; ch0 count 0 for codes 0-4 and 4 for codes 5-8; ch1 always 0.
- Backpressure: res_ready=0 for 10 cycles at code 3 -> res_valid held, res_code/res_count stable, launch stays 0, ctrl_c=8'h07; release gives one handshake and then code 4 starts.
- Abort/start priority: abort during the second LAUNCH of code 2 -> next cycle launch=0, busy=0, res_valid=0. start while busy -> ignored, with no change in code or trial. start and abort in the same IDLE cycle -> stays IDLE.
- Reset mid-sweep: rst_n low at code 5 asynchronously zeroes ctrl_c, launch, busy and res_valid. After release, start with mode=1 restarts from code 0.
- Synchroniser: arb_in[1] rises 1 cycle before the final LAUNCH cycle -> not counted in that trial; counted in the following trial if held.

Source files
------------

// File: rtl/pdl_sweep_ctrl.sv
// pdl_sweep_ctrl: drives the shared delay-control word of a bank of
// programmable delay lines, launches test edges and counts synchronised
// arbiter '1' responses per code. Static mode measures one configured word;
// sweep mode steps a thermometer code 0..N_LUT with one result per code.
module pdl_sweep_ctrl #(
  parameter int N_LUT   = 125,
  parameter int N_CH    = 1,
  parameter int SAMPLES = 16,
  parameter int SETTLE  = 4,
  parameter int HOLD    = 4,
  localparam int CW     = $clog2(N_LUT + 1),
  localparam int CNT_W  = $clog2(SAMPLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [N_LUT-1:0]        cfg_c,
  output logic [N_LUT-1:0]        ctrl_c,
  output logic                    launch,
  input  logic [N_CH-1:0]         arb_in,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CW-1:0]           res_code,
  output logic [N_CH*CNT_W-1:0]   res_count
);

  localparam int MAXD = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int TW   = $clog2(MAXD + 1);
  localparam int TRW  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RELAX  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [TRW-1:0]  trial;
  logic            sweep;
  logic [N_CH-1:0] arb_meta;
  logic [N_CH-1:0] arb_sync;

  // Low `c` bits set: the delay word selecting c LUTs.
  function automatic logic [N_LUT-1:0] therm(input logic [CW-1:0] c);
    logic [N_LUT-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < N_LUT; i++)
      t[i] = (i < 32'(c));
    return t;
  endfunction

  // Two-flop synchroniser for the asynchronous arbiter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_meta <= '0;
      arb_sync <= '0;
    end else begin
      arb_meta <= arb_in;
      arb_sync <= arb_meta;
    end
  end

  // Run sequencer; every output is registered and updated on the transition
  // edge, so launch/res_valid assert in the first cycle of their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      trial     <= '0;
      sweep     <= 1'b0;
      ctrl_c    <= '0;
      launch    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_code  <= '0;
      res_count <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      launch    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      res_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sweep     <= mode;
            res_code  <= '0;
            trial     <= '0;
            res_count <= '0;
            ctrl_c    <= mode ? '0 : cfg_c;
            busy      <= 1'b1;
            timer     <= TW'(SETTLE - 1);
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (timer == '0) begin
            launch <= 1'b1;
            timer  <= TW'(HOLD - 1);
            state  <= S_LAUNCH;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_LAUNCH: begin
          if (timer == '0) begin
            for (int unsigned i = 0; i < N_CH; i++)
              res_count[i*CNT_W +: CNT_W] <= res_count[i*CNT_W +: CNT_W] + CNT_W'(arb_sync[i]);
            launch <= 1'b0;
            timer  <= TW'(SETTLE - 1);
            state  <= S_RELAX;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_RELAX: begin
          if (timer == '0) begin
            if (trial != TRW'(SAMPLES - 1)) begin
              trial  <= trial + TRW'(1);
              launch <= 1'b1;
              timer  <= TW'(HOLD - 1);
              state  <= S_LAUNCH;
            end else begin
              res_valid <= 1'b1;
              state     <= S_REPORT;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!sweep || res_code == CW'(N_LUT)) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              res_code  <= res_code + CW'(1);
              ctrl_c    <= therm(res_code + CW'(1));
              trial     <= '0;
              res_count <= '0;
              timer     <= TW'(SETTLE - 1);
              state     <= S_SETUP;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          launch    <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdl_sweep_ctrl.sv
// Scoreboard bench for pdl_sweep_ctrl: expected results are queued when a
// run is started and compared when the DUT hands them over.
module tb_pdl_sweep_ctrl;

  localparam int N_LUT = 8, N_CH = 2, SAMPLES = 4, SETTLE = 2, HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, mode, res_ready;
  logic [7:0] cfg_c, ctrl_c;
  logic       launch, busy, res_valid;
  logic [1:0] arb_in, arb_man;
  logic       arb_follow;
  logic [3:0] res_code;
  logic [5:0] res_count;

  typedef struct {
    logic [3:0] code;
    logic [7:0] ctrl;
    logic [2:0] c0;
    logic [2:0] c1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  assign arb_in = arb_follow ? {arb_man[1], ctrl_c[4]} : arb_man;

  always #5 clk = ~clk;

  pdl_sweep_ctrl #(
    .N_LUT(N_LUT), .N_CH(N_CH), .SAMPLES(SAMPLES), .SETTLE(SETTLE), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .cfg_c(cfg_c), .ctrl_c(ctrl_c), .launch(launch), .arb_in(arb_in),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_code(res_code), .res_count(res_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sweep_exp(input int k);
    exp_t e;
    logic [8:0] t;
    t = (9'd1 << k) - 9'd1;
    e.code = 4'(k);
    e.ctrl = t[7:0];
    e.c0   = t[4] ? 3'(SAMPLES) : 3'd0;
    e.c1   = 3'd0;
    return e;
  endfunction

  task automatic push_sweep();
    for (int k = 0; k <= N_LUT; k++) q.push_back(sweep_exp(k));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_code(input logic [3:0] c, input string tag);
    int n = 0;
    while (res_code !== c && n < 300) begin tick(); n++; end
    chk(tag, 32'(res_code), 32'(c));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while (!launch && n < 100) begin tick(); n++; end
    chk(tag, 32'(launch), 32'd1);
  endtask

  // Handshake monitor: pops and compares one expected result per transfer.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_code",  32'(res_code),  32'(e.code));
        chk("sb_ctrl",  32'(ctrl_c),    32'(e.ctrl));
        chk("sb_count", 32'(res_count), 32'({e.c1, e.c0}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, rises, gap;
    logic prev;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; res_ready = 1'b0;
    cfg_c = 8'h00; arb_man = 2'b00; arb_follow = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", 32'(ctrl_c), 32'd0);
    chk("rst_launch", 32'(launch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(res_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Static measurement
    arb_man = 2'b01; mode = 1'b0; cfg_c = 8'hA5;
    q.push_back('{code: 4'd0, ctrl: 8'hA5, c0: 3'd4, c1: 3'd0});
    pulse_start();
    chk("st_busy", 32'(busy), 32'd1);
    chk("st_ctrl", 32'(ctrl_c), 32'hA5);
    n = 0;
    while (!res_valid && n < 60) begin tick(); n++; end
    chk("st_latency", 32'(n), 32'd22);
    chk("st_code", 32'(res_code), 32'd0);
    chk("st_count", 32'(res_count), 32'h04);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("st_busy_fall", 32'(busy), 32'd0);
    chk("st_valid_fall", 32'(res_valid), 32'd0);
    chk("st_q_empty", 32'(q.size()), 32'd0);

    // Full sweep, no backpressure
    arb_follow = 1'b1; arb_man = 2'b00; mode = 1'b1; res_ready = 1'b1;
    push_sweep();
    pulse_start();
    chk("sw_first_ctrl", 32'(ctrl_c), 32'h00);
    wait_idle("sw_done");
    chk("sw_q_empty", 32'(q.size()), 32'd0);
    chk("sw_ctrl_hold", 32'(ctrl_c), 32'hFF);

    // Backpressure at code 3
    push_sweep();
    pulse_start();
    wait_code(4'd3, "bp_reach3");
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 60) begin tick(); n++; end
    chk("bp_valid_up", 32'(res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_code", 32'(res_code), 32'd3);
      chk("bp_count", 32'(res_count), 32'd0);
      chk("bp_launch", 32'(launch), 32'd0);
      chk("bp_ctrl", 32'(ctrl_c), 32'h07);
    end
    res_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(res_valid), 32'd0);
    chk("bp_rel_code", 32'(res_code), 32'd4);
    chk("bp_rel_ctrl", 32'(ctrl_c), 32'h0F);
    wait_idle("bp_done");
    chk("bp_q_empty", 32'(q.size()), 32'd0);

    // Abort during second launch of code 2; start ignored while busy
    push_sweep();
    pulse_start();
    wait_code(4'd2, "ab_reach2");
    wait_launch("ab_first_launch");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ab_ign_code", 32'(res_code), 32'd2);
    chk("ab_ign_ctrl", 32'(ctrl_c), 32'h03);
    chk("ab_ign_busy", 32'(busy), 32'd1);
    prev = launch; rises = 0; gap = 1;
    while (rises == 0 && gap < 40) begin
      tick(); gap++;
      if (launch && !prev) rises++;
      prev = launch;
    end
    chk("ab_trial_gap", 32'(gap), 32'(HOLD + SETTLE));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_launch", 32'(launch), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_valid", 32'(res_valid), 32'd0);
    chk("ab_count", 32'(res_count), 32'd0);
    chk("ab_q_left", 32'(q.size()), 32'd7);
    q.delete();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    tick();
    chk("sa_busy2", 32'(busy), 32'd0);
    chk("sa_launch", 32'(launch), 32'd0);
    chk("sa_ctrl_hold", 32'(ctrl_c), 32'h03);

    // Asynchronous reset mid-sweep, then restart
    push_sweep();
    pulse_start();
    wait_code(4'd5, "rs_reach5");
    wait_launch("rs_launch_up");
    rst_n = 1'b0;
    #2;
    chk("rs_ctrl", 32'(ctrl_c), 32'd0);
    chk("rs_launch", 32'(launch), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_valid", 32'(res_valid), 32'd0);
    chk("rs_q_left", 32'(q.size()), 32'd4);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    res_ready = 1'b0;
    q.push_back(sweep_exp(0));
    pulse_start();
    chk("rs_re_busy", 32'(busy), 32'd1);
    chk("rs_re_code", 32'(res_code), 32'd0);
    chk("rs_re_ctrl", 32'(ctrl_c), 32'd0);
    n = 0;
    while (!res_valid && n < 60) begin tick(); n++; end
    chk("rs_re_latency", 32'(n), 32'd22);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rs_q_empty", 32'(q.size()), 32'd0);

    // Synchroniser latency: late rise in trial 0 is not counted
    arb_follow = 1'b0; arb_man = 2'b00; mode = 1'b0; cfg_c = 8'h3C; res_ready = 1'b1;
    q.push_back('{code: 4'd0, ctrl: 8'h3C, c0: 3'd0, c1: 3'd3});
    pulse_start();
    wait_launch("sy_launch");
    tick();
    arb_man[1] = 1'b1;
    wait_idle("sy_done");
    chk("sy_q_empty", 32'(q.size()), 32'd0);
    arb_man = 2'b00;
    res_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
